pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencer for the ID stage of the 5-stage RISC-V core. It owns the PC / IF-ID register write enables, bubble insertion into ID/EX, IF-ID flush and global freeze. It resolves load-use hazards from the ID instruction's rs fields, flushes fetched instructions after branches taken in ID, and freezes the pipeline during data-memory stalls. It also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage sequencer for load-use stalls, branch flushes, memory freezes and perf counters
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      ID_instr_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             bubble_o,
  output logic             IF_ID_flush_o,
  output logic             pipe_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_MWAIT} state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_SB = 7'b1100011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);
  state_t           r_state, r_ret;
  logic [3:0]       r_fcnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [6:0]       w_op;
  logic [4:0]       w_rs1, w_rs2;
  logic             w_use_rs1, w_use_rs2, w_load_use;
  logic             w_run, w_flush_st, w_active, w_frz, w_stall, w_br;
  assign w_op      = ID_instr_i[6:0];
  assign w_rs1     = ID_instr_i[19:15];
  assign w_rs2     = ID_instr_i[24:20];
  assign w_use_rs2 = (w_op == OP_R) || (w_op == OP_S) || (w_op == OP_SB);
  assign w_use_rs1 = w_use_rs2 || (w_op == OP_I) || (w_op == OP_LD);
  assign w_load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == EX_rd_i)) || (w_use_rs2 && (w_rs2 == EX_rd_i)));
  assign w_run      = (r_state == S_RUN);
  assign w_flush_st = (r_state == S_FLUSH);
  assign w_active   = (w_run || w_flush_st) && !mem_stall_i;
  // MWAIT freezes unconditionally so the cycle mem_stall_i drops is the single recovery cycle
  assign w_frz      = (r_state == S_MWAIT) || ((w_run || w_flush_st) && mem_stall_i);
  assign w_stall    = w_run && !mem_stall_i && w_load_use;
  assign w_br       = w_run && !mem_stall_i && !w_load_use && branch_taken_i;
  assign PC_write_o    = w_active && !w_stall;
  assign IF_ID_write_o = w_active && !w_stall;
  assign bubble_o      = (r_state == S_IDLE) || w_stall;
  assign IF_ID_flush_o = w_br || (w_flush_st && !mem_stall_i);
  assign pipe_stall_o  = w_frz;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ret       <= S_RUN;
      r_fcnt      <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) r_state <= S_RUN;
        S_RUN: begin
          if (mem_stall_i) begin
            r_ret   <= S_RUN;
            r_state <= S_MWAIT;
          end else if (w_br && FLUSH_CYCLES > 1) begin
            r_fcnt  <= FC_INIT;
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (mem_stall_i) begin
            r_ret   <= S_FLUSH;
            r_state <= S_MWAIT;
          end else begin
            r_fcnt <= r_fcnt - 4'd1;
            if (r_fcnt == 4'd1) r_state <= S_RUN;
          end
        end
        S_MWAIT: if (!mem_stall_i) r_state <= r_ret;
        default: r_state <= S_IDLE;
      endcase
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_br && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench over three parameterisations sharing one stimulus bus
module tb_pipeline_hazard_ctrl;
  localparam logic [4:0] IDLE_O = 5'b00100, RUN_O = 5'b11000, STL_O = 5'b00100;
  localparam logic [4:0] FL_O = 5'b11010, FRZ_O = 5'b00001;
  localparam logic [31:0] ADD = 32'h0072_8333, LUI = 32'h0002_8337, SW = 32'h0051_2023;
  localparam logic [31:0] ADDI_IMM5 = 32'h0051_0093, ADDI_X0 = 32'h0010_0093;
  typedef struct {string tag; int k; logic [4:0] v;} exp_t;
  logic clk = 0, rst = 1, start = 0, mem_rd = 0, br = 0, mstall = 0;
  logic [31:0] instr = 32'h0;
  logic [4:0] rd = 5'd0;
  logic [2:0] pcw, ifw, bub, fl, ps;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [1:0] sc2, fc2;
  int checks = 0, failures = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_f2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ID_instr_i(instr), .EX_MemRead_i(mem_rd),
    .EX_rd_i(rd), .branch_taken_i(br), .mem_stall_i(mstall), .PC_write_o(pcw[0]),
    .IF_ID_write_o(ifw[0]), .bubble_o(bub[0]), .IF_ID_flush_o(fl[0]), .pipe_stall_o(ps[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) u_f3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ID_instr_i(instr), .EX_MemRead_i(mem_rd),
    .EX_rd_i(rd), .branch_taken_i(br), .mem_stall_i(mstall), .PC_write_o(pcw[1]),
    .IF_ID_write_o(ifw[1]), .bubble_o(bub[1]), .IF_ID_flush_o(fl[1]), .pipe_stall_o(ps[1]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_c2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ID_instr_i(instr), .EX_MemRead_i(mem_rd),
    .EX_rd_i(rd), .branch_taken_i(br), .mem_stall_i(mstall), .PC_write_o(pcw[2]),
    .IF_ID_write_o(ifw[2]), .bubble_o(bub[2]), .IF_ID_flush_o(fl[2]), .pipe_stall_o(ps[2]),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2));
  function automatic logic [4:0] obs(int k);
    return {pcw[k], ifw[k], bub[k], fl[k], ps[k]};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic step(string tag, int k, logic [4:0] v);
    q.push_back('{tag, k, v});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, 64'(obs(e.k)), 64'(e.v));
    end
  end
  initial begin
    @(posedge clk);
    #1;
    rst = 0;
    step("idle0", 0, IDLE_O);
    step("idle1", 0, IDLE_O);
    chk("rst_sc", 64'(sc0), 0);
    chk("rst_fc", 64'(fc0), 0);
    start = 1;
    step("start", 0, IDLE_O);
    start = 0;
    step("run", 0, RUN_O);
    mem_rd = 1; rd = 5; instr = ADD;
    step("lu", 0, STL_O);
    mem_rd = 0;
    step("lu_end", 0, RUN_O);
    chk("sc_lu", 64'(sc0), 1);
    mem_rd = 1; instr = LUI;
    step("lui", 0, RUN_O);
    instr = SW;
    step("sw_rs2", 0, STL_O);
    instr = ADDI_IMM5;
    step("addi_imm", 0, RUN_O);
    rd = 0; instr = ADDI_X0;
    step("rd0", 0, RUN_O);
    chk("sc_decode", 64'(sc0), 2);
    mem_rd = 0; br = 1;
    step("br", 0, FL_O);
    br = 0;
    step("br_fl2", 0, FL_O);
    step("br_end", 0, RUN_O);
    chk("fc_br", 64'(fc0), 1);
    mem_rd = 1; rd = 5; instr = ADD; br = 1;
    step("lu_br", 0, STL_O);
    mem_rd = 0; br = 0;
    step("lu_br_end", 0, RUN_O);
    chk("fc_lu_br", 64'(fc0), 1);
    chk("sc_lu_br", 64'(sc0), 3);
    mstall = 1; mem_rd = 1;
    step("ms", 0, FRZ_O);
    mstall = 0; mem_rd = 0;
    step("ms_rec", 0, FRZ_O);
    step("ms_end", 0, RUN_O);
    chk("sc_ms", 64'(sc0), 3);
    rst = 1;
    step("rst_mid", 0, RUN_O);
    rst = 0;
    chk("rst_mid_sc", 64'(sc0), 0);
    chk("rst_mid_fc", 64'(fc0), 0);
    step("rst_idle", 0, IDLE_O);
    start = 1;
    step("b_start", 1, IDLE_O);
    start = 0;
    step("b_run", 1, RUN_O);
    br = 1;
    step("b_br", 1, FL_O);
    br = 0; mstall = 1;
    step("b_ms1", 1, FRZ_O);
    step("b_ms2", 1, FRZ_O);
    step("b_ms3", 1, FRZ_O);
    mstall = 0;
    step("b_rec", 1, FRZ_O);
    mem_rd = 1; rd = 5; instr = ADD; br = 1;
    step("b_fl1", 1, FL_O);
    mem_rd = 0; br = 0;
    step("b_fl2", 1, FL_O);
    step("b_end", 1, RUN_O);
    chk("b_fc", 64'(fc1), 1);
    chk("b_sc", 64'(sc1), 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    start = 1;
    step("c_start", 2, IDLE_O);
    start = 0;
    mem_rd = 1; rd = 5; instr = ADD;
    for (int i = 0; i < 5; i++) begin
      step("c_lu", 2, STL_O);
      if (i == 1) chk("c_sc_cnt", 64'(sc2), 2);
    end
    mem_rd = 0;
    chk("c_sc_sat", 64'(sc2), 3);
    br = 1;
    for (int i = 0; i < 4; i++) step("c_br", 2, FL_O);
    br = 0;
    step("c_run", 2, RUN_O);
    chk("c_fc_sat", 64'(fc2), 3);
    @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
